rps_panel_draw_scheduler: RTL and testbench

- Sequences and arbitrates the single vga_adapter write port between two draw requesters: the computer panel (left) and the user panel (right).
- On a granted request it scans the panel pixel by pixel and addresses the shared rock/scissor/paper image ROMs.
- It aligns each ROM output with its pixel coordinates, applies the panel's colour scheme, and drives x/y/plot/colour into vga_adapter (160x120).

---
 rtl/rps_panel_draw_scheduler_pkg.sv | 42 ++++
 rtl/rps_panel_draw_scheduler_chk.sv | 14 +
 rtl/rps_panel_scan_counter.sv | 66 ++++++
 rtl/rps_panel_draw_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_rps_panel_draw_scheduler.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rps_panel_draw_scheduler_pkg.sv
// Shared types and constants for the rock/paper/scissors panel draw scheduler.
package rps_panel_draw_scheduler_pkg;

    localparam int LX_W   = 7;
    localparam int LY_W   = 7;
    localparam int ADDR_W = 15;
    localparam int X_W    = 8;

    localparam logic [1:0] ROCK    = 2'b00;
    localparam logic [1:0] SCISSOR = 2'b01;
    localparam logic [1:0] PAPER   = 2'b10;

    localparam logic [2:0] FIG_GREEN = 3'b010;
    localparam logic [2:0] BG_WHITE  = 3'b111;
    localparam logic [2:0] BG_BLACK  = 3'b000;

    typedef enum logic {PANEL_C = 1'b0, PANEL_U = 1'b1} panel_e;

    typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, FLUSH = 2'b10} state_e;

    typedef struct packed {
        logic              valid;
        logic              last;
        panel_e            panel;
        logic [LX_W-1:0]   lx;
        logic [LY_W-1:0]   ly;
    } pix_t;

    // ROM data 0 marks the figure; the background shade depends on the panel.
    function automatic logic [2:0] map_colour(input logic q, input panel_e panel);
        logic [2:0] c;
        if (!q) begin
            c = FIG_GREEN;
        end else if (panel == PANEL_C) begin
            c = BG_WHITE;
        end else begin
            c = BG_BLACK;
        end
        return c;
    endfunction

endpackage

// File: rtl/rps_panel_draw_scheduler_chk.sv
// Parameter legality checks for the draw scheduler: both panels must fit the 160-pixel screen.
module rps_panel_draw_scheduler_chk #(
    parameter int PANEL_W = 80,
    parameter int X_OFF_C = 0,
    parameter int X_OFF_U = 80
) (
    input logic CLOCK_50,
    input logic reset_n
);

    a_panels_fit_screen: assert property (@(posedge CLOCK_50) disable iff (!reset_n)
        ((X_OFF_C + PANEL_W) <= 160) && ((X_OFF_U + PANEL_W) <= 160));

endmodule

// File: rtl/rps_panel_scan_counter.sv
// Raster counter over one panel: lx/ly position, registered ROM address and last-pixel flag.
module rps_panel_scan_counter
    import rps_panel_draw_scheduler_pkg::*;
#(
    parameter int PANEL_W = 80,
    parameter int PANEL_H = 120
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic              adv,
    output logic [LX_W-1:0]   lx,
    output logic [LY_W-1:0]   ly,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [LX_W-1:0]   lx_q, lx_d;
    logic [LY_W-1:0]   ly_q, ly_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Next position; the address register always holds ly*PANEL_W + lx of the position registers.
    always_comb begin
        lx_d = lx_q;
        ly_d = ly_q;
        if (start) begin
            lx_d = {LX_W{1'b0}};
            ly_d = {LY_W{1'b0}};
        end else if (adv) begin
            if (lx_q == LX_W'(PANEL_W - 1)) begin
                lx_d = {LX_W{1'b0}};
                if (ly_q == LY_W'(PANEL_H - 1)) begin
                    ly_d = {LY_W{1'b0}};
                end else begin
                    ly_d = ly_q + LY_W'(1);
                end
            end else begin
                lx_d = lx_q + LX_W'(1);
                ly_d = ly_q;
            end
        end else begin
            lx_d = lx_q;
            ly_d = ly_q;
        end
        addr_d = ADDR_W'(ly_d) * ADDR_W'(PANEL_W) + ADDR_W'(lx_d);
    end

    // Position and address registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            lx_q   <= {LX_W{1'b0}};
            ly_q   <= {LY_W{1'b0}};
            addr_q <= {ADDR_W{1'b0}};
        end else begin
            lx_q   <= lx_d;
            ly_q   <= ly_d;
            addr_q <= addr_d;
        end
    end

    assign lx   = lx_q;
    assign ly   = ly_q;
    assign addr = addr_q;
    assign last = (lx_q == LX_W'(PANEL_W - 1)) && (ly_q == LY_W'(PANEL_H - 1));

endmodule

// File: rtl/rps_panel_draw_scheduler.sv
// Arbitrates the vga_adapter write port between the computer and user panels and
// streams each panel's ROM image, colour-mapped, as consecutive plot pulses.
module rps_panel_draw_scheduler
    import rps_panel_draw_scheduler_pkg::*;
#(
    parameter int PANEL_W = 80,
    parameter int PANEL_H = 120,
    parameter int X_OFF_C = 0,
    parameter int X_OFF_U = 80,
    parameter int ROM_LAT = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        req_c,
    input  logic        req_u,
    input  logic [1:0]  choice_c,
    input  logic [1:0]  choice_u,
    output logic [14:0] rom_addr,
    input  logic        q_r,
    input  logic        q_s,
    input  logic        q_p,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        plot,
    output logic [2:0]  colour,
    output logic        busy,
    output logic        done_c,
    output logic        done_u
);

    state_e          state_q, state_d;
    panel_e          panel_q, panel_d, last_served_q, last_served_d;
    logic            pending_c_q, pending_c_d, pending_u_q, pending_u_d;
    logic [1:0]      choice_q, choice_d;
    logic [3:0]      flush_cnt_q, flush_cnt_d;
    logic            busy_q, busy_d;
    logic            grant_c_s, grant_u_s, start_s, adv_s, last_s;
    logic [LX_W-1:0] lx_s;
    logic [LY_W-1:0] ly_s;

    pix_t            head_s, tail_s;
    pix_t            pipe_q [ROM_LAT];
    pix_t            pipe_d [ROM_LAT];
    logic            q_sel_s;

    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic            plot_q, plot_d;
    logic [2:0]      colour_q, colour_d;
    logic            done_c_q, done_c_d, done_u_q, done_u_d;

    rps_panel_scan_counter #(
        .PANEL_W (PANEL_W),
        .PANEL_H (PANEL_H)
    ) u_scan (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .start    (start_s),
        .adv      (adv_s),
        .lx       (lx_s),
        .ly       (ly_s),
        .addr     (rom_addr),
        .last     (last_s)
    );

    rps_panel_draw_scheduler_chk #(
        .PANEL_W (PANEL_W),
        .X_OFF_C (X_OFF_C),
        .X_OFF_U (X_OFF_U)
    ) u_chk (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n)
    );

    // Arbitration and draw sequencing; a tie goes to the panel not served last.
    always_comb begin
        state_d       = state_q;
        panel_d       = panel_q;
        last_served_d = last_served_q;
        choice_d      = choice_q;
        flush_cnt_d   = flush_cnt_q;
        busy_d        = busy_q;
        grant_c_s     = 1'b0;
        grant_u_s     = 1'b0;
        start_s       = 1'b0;
        adv_s         = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_c_q && (!pending_u_q || (last_served_q == PANEL_U))) begin
                    grant_c_s = 1'b1;
                end else if (pending_u_q) begin
                    grant_u_s = 1'b1;
                end else begin
                    grant_c_s = 1'b0;
                end
                if (grant_c_s || grant_u_s) begin
                    start_s  = 1'b1;
                    panel_d  = grant_c_s ? PANEL_C : PANEL_U;
                    choice_d = grant_c_s ? choice_c : choice_u;
                    busy_d   = 1'b1;
                    state_d  = SCAN;
                end else begin
                    state_d  = IDLE;
                end
            end
            SCAN: begin
                adv_s = 1'b1;
                if (last_s) begin
                    flush_cnt_d = 4'd0;
                    state_d     = FLUSH;
                end else begin
                    state_d     = SCAN;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 4'(ROM_LAT)) begin
                    busy_d        = 1'b0;
                    last_served_d = panel_q;
                    state_d       = IDLE;
                end else begin
                    flush_cnt_d   = flush_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A request arriving in its own grant cycle still earns one more draw.
        pending_c_d = (pending_c_q & ~grant_c_s) | req_c;
        pending_u_d = (pending_u_q & ~grant_u_s) | req_u;
    end

    // Control registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            panel_q       <= PANEL_C;
            last_served_q <= PANEL_U;
            pending_c_q   <= 1'b0;
            pending_u_q   <= 1'b0;
            choice_q      <= 2'b00;
            flush_cnt_q   <= 4'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            panel_q       <= panel_d;
            last_served_q <= last_served_d;
            pending_c_q   <= pending_c_d;
            pending_u_q   <= pending_u_d;
            choice_q      <= choice_d;
            flush_cnt_q   <= flush_cnt_d;
            busy_q        <= busy_d;
        end
    end

    // Pixel tags travel ROM_LAT stages so they arrive together with the ROM data.
    always_comb begin
        head_s.valid = (state_q == SCAN);
        head_s.last  = (state_q == SCAN) && last_s;
        head_s.panel = panel_q;
        head_s.lx    = lx_s;
        head_s.ly    = ly_s;
        pipe_d[0]    = head_s;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Tag delay line.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tail_s = pipe_q[ROM_LAT-1];

    // Image select; choice_q is frozen until the pipeline has drained.
    always_comb begin
        case (choice_q)
            ROCK:    q_sel_s = q_r;
            SCISSOR: q_sel_s = q_s;
            default: q_sel_s = q_p;
        endcase
    end

    // Output stage toward vga_adapter.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = tail_s.valid;
        done_c_d = tail_s.valid && tail_s.last && (tail_s.panel == PANEL_C);
        done_u_d = tail_s.valid && tail_s.last && (tail_s.panel == PANEL_U);
        if (tail_s.valid) begin
            x_d      = ((tail_s.panel == PANEL_C) ? X_W'(X_OFF_C) : X_W'(X_OFF_U)) + X_W'(tail_s.lx);
            y_d      = tail_s.ly;
            colour_d = map_colour(q_sel_s, tail_s.panel);
        end else begin
            x_d      = x_q;
            y_d      = y_q;
            colour_d = colour_q;
        end
    end

    // Output registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            plot_q   <= 1'b0;
            colour_q <= 3'b000;
            done_c_q <= 1'b0;
            done_u_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            plot_q   <= plot_d;
            colour_q <= colour_d;
            done_c_q <= done_c_d;
            done_u_q <= done_u_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign plot   = plot_q;
    assign colour = colour_q;
    assign busy   = busy_q;
    assign done_c = done_c_q;
    assign done_u = done_u_q;

endmodule

// File: tb/tb_rps_panel_draw_scheduler.sv
// Directed bench for rps_panel_draw_scheduler with a 1-cycle-latency ROM model.
module tb_rps_panel_draw_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        req_c, req_u;
    logic [1:0]  choice_c, choice_u;
    logic [14:0] rom_addr;
    logic        q_r, q_s, q_p;
    logic [7:0]  x;
    logic [6:0]  y;
    logic        plot;
    logic [2:0]  colour;
    logic        busy, done_c, done_u;

    int n_checks = 0;
    int n_pass   = 0;

    rps_panel_draw_scheduler dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .req_c    (req_c),
        .req_u    (req_u),
        .choice_c (choice_c),
        .choice_u (choice_u),
        .rom_addr (rom_addr),
        .q_r      (q_r),
        .q_s      (q_s),
        .q_p      (q_p),
        .x        (x),
        .y        (y),
        .plot     (plot),
        .colour   (colour),
        .busy     (busy),
        .done_c   (done_c),
        .done_u   (done_u)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Three distinct images; scissor is a checkerboard over the panel.
    function automatic logic f_r(input int a);
        return logic'(((a / 2) + (a / 8)) % 2);
    endfunction
    function automatic logic f_s(input int a);
        return logic'(((a % 80) + (a / 80)) % 2);
    endfunction
    function automatic logic f_p(input int a);
        return (a % 13) >= 5;
    endfunction

    always @(posedge CLOCK_50) begin
        q_r <= f_r(int'(rom_addr));
        q_s <= f_s(int'(rom_addr));
        q_p <= f_p(int'(rom_addr));
    end

    function automatic logic [2:0] exp_col(input int pc, input logic [1:0] ch, input bit is_c);
        logic q;
        if (ch == 2'b00)      q = f_r(pc);
        else if (ch == 2'b01) q = f_s(pc);
        else                  q = f_p(pc);
        if (!q)        return 3'b010;
        else if (is_c) return 3'b111;
        else           return 3'b000;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Watch one draw at negedges. action 1: flip choice_u mid-draw; action 2: re-request user 3x.
    task automatic observe(input string tag, input int off, input logic [1:0] ch,
                           input bit is_c, input int action, input int stop_px);
        int pc = 0, perr = 0, gaps = 0, dc = 0, du = 0, dmis = 0, cyc = 0;
        int fx = -1, fy = -1, lxv = -1, lyv = -1;
        bit prev = 1'b0, done = 1'b0;
        logic busy_done = 1'b0, busy_after = 1'b1;
        while (!done && cyc < 12000 && !(stop_px > 0 && pc >= stop_px)) begin
            @(negedge CLOCK_50);
            cyc++;
            req_c = 1'b0;
            req_u = 1'b0;
            if (plot) begin
                if (pc == 0) begin
                    fx = int'(x);
                    fy = int'(y);
                end else if (!prev) begin
                    gaps++;
                end
                if (int'(x) != off + pc % 80 || int'(y) != pc / 80) perr++;
                if (colour != exp_col(pc, ch, is_c)) perr++;
                lxv = int'(x);
                lyv = int'(y);
                pc++;
            end
            prev = plot;
            if (done_c || done_u) begin
                if (!plot || pc != 9600) dmis++;
                if (done_c) dc++;
                if (done_u) du++;
                busy_done = busy;
                done = 1'b1;
            end
            if (action == 1 && pc == 3000) choice_u = 2'b10;
            if (action == 2 && (pc == 1000 || pc == 2000 || pc == 3000)) req_u = 1'b1;
        end
        if (stop_px == 0) begin
            @(negedge CLOCK_50);
            busy_after = busy;
            check_eq({tag, " done_seen"}, int'(done), 1);
            check_eq({tag, " plot_count"}, pc, 9600);
            check_eq({tag, " pixel_errors"}, perr, 0);
            check_eq({tag, " plot_gaps"}, gaps, 0);
            check_eq({tag, " first_x"}, fx, off);
            check_eq({tag, " first_y"}, fy, 0);
            check_eq({tag, " last_x"}, lxv, off + 79);
            check_eq({tag, " last_y"}, lyv, 119);
            check_eq({tag, " done_c_n"}, dc, is_c ? 1 : 0);
            check_eq({tag, " done_u_n"}, du, is_c ? 0 : 1);
            check_eq({tag, " done_not_on_last"}, dmis, 0);
            check_eq({tag, " busy_at_done"}, int'(busy_done), 1);
            check_eq({tag, " busy_after_done"}, int'(busy_after), 0);
        end else begin
            check_eq({tag, " reached_px"}, pc, stop_px);
        end
    endtask

    task automatic idle_check(input string tag, input int ncyc);
        int np = 0, nd = 0, nb = 0;
        repeat (ncyc) begin
            @(negedge CLOCK_50);
            np += int'(plot);
            nd += int'(done_c | done_u);
            nb += int'(busy);
        end
        check_eq({tag, " plots"}, np, 0);
        check_eq({tag, " dones"}, nd, 0);
        check_eq({tag, " busy_cycles"}, nb, 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        req_c    = 1'b0;
        req_u    = 1'b0;
        choice_c = 2'b00;
        choice_u = 2'b00;
        repeat (3) @(negedge CLOCK_50);
        check_eq("rst plot", int'(plot), 0);
        check_eq("rst busy", int'(busy), 0);
        check_eq("rst done_c", int'(done_c), 0);
        check_eq("rst done_u", int'(done_u), 0);
        check_eq("rst x", int'(x), 0);
        check_eq("rst y", int'(y), 0);
        check_eq("rst colour", int'(colour), 0);
        check_eq("rst rom_addr", int'(rom_addr), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // Tie straight after reset: computer (rock) first, then user (paper).
        choice_c = 2'b00;
        choice_u = 2'b10;
        req_c    = 1'b1;
        req_u    = 1'b1;
        observe("tie1_c", 0, 2'b00, 1'b1, 0, 0);
        observe("tie1_u", 80, 2'b10, 1'b0, 0, 0);
        idle_check("tie1_idle", 10);

        // Computer alone with scissor.
        choice_c = 2'b01;
        req_c    = 1'b1;
        observe("c_scissor", 0, 2'b01, 1'b1, 0, 0);

        // Tie after a computer draw: user first (checkerboard, choice flips mid-draw), then computer paper 11.
        choice_u = 2'b01;
        choice_c = 2'b11;
        req_c    = 1'b1;
        req_u    = 1'b1;
        observe("tie2_u_chk", 80, 2'b01, 1'b0, 1, 0);
        observe("tie2_c_paper", 0, 2'b11, 1'b1, 0, 0);
        idle_check("tie2_idle", 10);

        // Three re-requests during a user draw collapse into one extra draw.
        choice_u = 2'b00;
        req_u    = 1'b1;
        observe("urep_1", 80, 2'b00, 1'b0, 2, 0);
        observe("urep_2", 80, 2'b00, 1'b0, 0, 0);
        idle_check("urep_idle", 100);

        // Reset mid-draw with a pending re-request.
        choice_u = 2'b01;
        req_u    = 1'b1;
        observe("rst_mid", 80, 2'b01, 1'b0, 2, 5000);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid plot_async", int'(plot), 0);
        check_eq("rst_mid busy_async", int'(busy), 0);
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        idle_check("rst_mid_after", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
